// File: rtl/btn_events_if.sv
// Button event bundle: the level inputs that drive the event FSM and
// the registered event outputs that come back from it.
// The repeat pulse is named repeat_p because "repeat" is a reserved word.
interface btn_events_if;
  logic en;
  logic btn;
  logic press;
  logic release_p;
  logic long_press;
  logic repeat_p;
  logic held;

  modport master (
    output en, btn,
    input  press, release_p, long_press, repeat_p, held
  );

  modport slave (
    input  en, btn,
    output press, release_p, long_press, repeat_p, held
  );
endinterface

// File: rtl/btn_events.sv
// Button event generator: converts a debounced button level into press,
// release, long-press and auto-repeat pulses, plus a held level.
// A single counter times both the long-press delay and the repeat period.
module btn_events #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic         clk,
  input  logic         rst,
  btn_events_if.slave  bus
);

  localparam int MAXC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          press_q, release_q, long_q, repeat_q, held_q;
  logic          press_n, release_n, long_n, repeat_n;

  // Next state, counter and pulse decisions; en=0 outranks btn, and a
  // release at a terminal count wins over the long/repeat pulse.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.en && bus.btn) begin
          state_n = PRESSED;
          press_n = 1'b1;
        end
      end
      PRESSED: begin
        if (!bus.en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!bus.btn) begin
          state_n   = IDLE;
          cnt_n     = '0;
          release_n = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = LONG;
          cnt_n   = '0;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LONG: begin
        if (!bus.en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!bus.btn) begin
          state_n   = IDLE;
          cnt_n     = '0;
          release_n = 1'b1;
        end else if (cnt == REP_LAST) begin
          cnt_n    = '0;
          repeat_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; held tracks the next state so
  // it is high exactly while the registered state is PRESSED or LONG.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      press_q   <= press_n;
      release_q <= release_n;
      long_q    <= long_n;
      repeat_q  <= repeat_n;
      held_q    <= (state_n != IDLE);
    end
  end

  assign bus.press      = press_q;
  assign bus.release_p  = release_q;
  assign bus.long_press = long_q;
  assign bus.repeat_p   = repeat_q;
  assign bus.held       = held_q;

endmodule

// File: tb/tb_btn_events.sv
// Testbench for btn_events: directed scenarios followed by a random
// btn/en/rst stream, checked through an expected-value queue against a
// hold-duration reference model.
module tb_btn_events;
  localparam int L = 5;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_events_if bus();

  btn_events #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic press;
    logic rel;
    logic lng;
    logic rep;
    logic held;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: is a hold in progress, and how many edges since the press.
  bit   m_hold = 1'b0;
  int   m_age  = 0;

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic step(input logic r, input logic e, input logic b);
    exp_t x;
    x = '0;
    rst = r; bus.en = e; bus.btn = b;
    if (r) begin
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (e && b) begin
        x.press = 1'b1;
        m_hold  = 1'b1;
        m_age   = 0;
      end
    end else if (!e) begin
      m_hold = 1'b0;
    end else if (!b) begin
      x.rel  = 1'b1;
      m_hold = 1'b0;
    end else begin
      m_age++;
      if (m_age == L) x.lng = 1'b1;
      else if (m_age > L && (m_age - L) % R == 0) x.rep = 1'b1;
    end
    x.held = m_hold;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic e, input logic b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, e, b);
  endtask

  // Monitor: after every edge, pop the expected outputs and compare.
  exp_t mon_e, mon_a;
  initial begin
    forever begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        mon_a = '{bus.press, bus.release_p, bus.long_press, bus.repeat_p, bus.held};
        tests++;
        if (mon_a !== mon_e) begin
          fails++;
          $display("FAIL outputs cycle %0d: got press/rel/long/rep/held=%b expected %b",
                   cyc, mon_a, mon_e);
        end
        tests++;
        if ($countones({bus.press, bus.release_p, bus.long_press, bus.repeat_p}) > 1) begin
          fails++;
          $display("FAIL onehot cycle %0d: got pulses %b expected at most one high",
                   cyc, mon_a[4:1]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.btn = 1'b0;
    // reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    run(1'b1, 1'b0, 2);
    // short tap
    run(1'b1, 1'b1, 3);  run(1'b1, 1'b0, 3);
    // long hold with repeats
    run(1'b1, 1'b1, 15); run(1'b1, 1'b0, 3);
    // release at the edge where the long count terminates
    run(1'b1, 1'b1, 5);  run(1'b1, 1'b0, 3);
    // en dropped during LONG, then restored with btn still high
    run(1'b1, 1'b1, 8);  run(1'b0, 1'b1, 2); run(1'b1, 1'b1, 3); run(1'b1, 1'b0, 2);
    // rst pulse mid-hold
    run(1'b1, 1'b1, 4);  step(1'b1, 1'b1, 1'b1); run(1'b1, 1'b1, 3); run(1'b1, 1'b0, 2);
    // btn already high while disabled, then enabled
    run(1'b0, 1'b1, 2);  run(1'b1, 1'b1, 2); run(1'b1, 1'b0, 2);
    // random stream
    begin
      logic b;
      b = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) b = ~b;
        step(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) != 0), b);
      end
    end
    run(1'b1, 1'b0, 2);
    // drain the queue with a bound
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_events.md
BTN_EVENTS -- requirements
Module: btn_events

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 50000000, cycles a press must be held before long_press fires; legal range is 2 or more.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 10000000, period between repeat pulses once long-held; legal range is 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: event generation enable.
REQ-006 The block SHALL have port btn, input, 1 bit: debounced, clk-synchronous, active-high button level from the debounce stage.
REQ-007 The block SHALL have port press, output, 1 bit: one-cycle pulse on press.
REQ-008 The block SHALL have port release_p, output, 1 bit: one-cycle pulse on release.
REQ-009 The block SHALL have port long_press, output, 1 bit: one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-010 The block SHALL have port repeat, output, 1 bit: one-cycle pulse every REPEAT_CYCLES during a long hold.
REQ-011 The block SHALL have port held, output, 1 bit: level, high while the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, PRESSED and LONG.
REQ-013 The FSM SHALL use one counter, cnt, unsigned and wide enough to hold max(LONG_CYCLES, REPEAT_CYCLES)-1; cnt SHALL never wrap.
REQ-014 All outputs SHALL be registered; press, release_p, long_press and repeat SHALL default to 0 on every cycle not named below.
REQ-015 IDLE with en=1 and btn=1 at an edge SHALL move to PRESSED, set cnt to 0, and drive press=1 for the following cycle.
REQ-016 IDLE with btn=0 or en=0 SHALL stay in IDLE with cnt=0.
REQ-017 PRESSED with btn=0 SHALL move to IDLE and drive release_p=1 for one cycle; long_press SHALL NOT fire.
REQ-018 PRESSED with btn=1 and cnt=LONG_CYCLES-1 SHALL move to LONG, set cnt to 0, and drive long_press=1 for one cycle.
REQ-019 The long_press pulse SHALL therefore appear exactly LONG_CYCLES cycles after the press pulse.
REQ-020 PRESSED with btn=1 and cnt below LONG_CYCLES-1 SHALL increment cnt.
REQ-021 LONG with btn=0 SHALL move to IDLE and drive release_p=1 for one cycle.
REQ-022 LONG with btn=1 and cnt=REPEAT_CYCLES-1 SHALL drive repeat=1 for one cycle and set cnt to 0, so repeat pulses fall REPEAT_CYCLES, 2*REPEAT_CYCLES, ... cycles after long_press.
REQ-023 LONG with btn=1 and cnt below REPEAT_CYCLES-1 SHALL increment cnt.
REQ-024 en=0 in PRESSED or LONG SHALL force IDLE and cnt=0 at the next edge with no release_p pulse; en=0 SHALL take priority over btn.
REQ-025 At most one of press, release_p, long_press and repeat SHALL be high in any cycle.
REQ-026 Where the btn level changes at the same edge a count terminates, the release (btn=0) SHALL win and no long_press or repeat SHALL fire.
REQ-027 held SHALL be 1 exactly in the cycles the registered state is PRESSED or LONG.
REQ-028 If btn is already high when en rises, or when rst deasserts, a press SHALL be produced, following the IDLE rule; no prior edge is required.

Reset
REQ-029 rst=1 at an edge SHALL force state IDLE, cnt=0, and press, release_p, long_press, repeat and held all 0, overriding every other input.
REQ-030 rst asserted mid-hold SHALL produce no release_p pulse.
REQ-031 After rst deasserts, normal operation SHALL resume at the next edge.

Verification (LONG_CYCLES=5, REPEAT_CYCLES=3)
REQ-032 Short tap: btn high 3 cycles -> one press pulse, held high 3 cycles, one release_p; long_press and repeat never assert.
REQ-033 Long hold of 15 cycles -> press at t0, long_press at t0+5, repeat at t0+8, t0+11 and t0+14, then release_p after btn falls.
REQ-034 Boundary: btn falls at the exact edge where cnt=4 in PRESSED -> release_p only, with no long_press.
REQ-035 en dropped to 0 during LONG -> held falls next cycle with no release_p; btn still high with en back to 1 -> a fresh press.
REQ-036 rst pulsed for 1 cycle mid-hold -> all outputs 0 with no release_p; btn still high after rst -> press the next cycle.
REQ-037 Random btn/en/rst stream against a reference model -> the pulse one-hot property holds every cycle and every output matches the model.
